// File: rtl/minifloat_frame_accumulator.sv
// Decodes 7-bit minifloat codes to integers and accumulates them per frame.
// A decode register feeds an accumulate register; one result word is held per frame until it is taken.
//
// state   | meaning
// ACCUM   | accepting codes
// CLOSING | close pending, last element sitting in stage 1
// HOLD    | frame result valid, waiting for out_ready
module minifloat_frame_accumulator #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic [2:0]       out_max_exp
);

  typedef enum logic [1:0] {ACCUM, CLOSING, HOLD} state_t;

  state_t           state, state_nxt;
  logic             close_pending;
  logic             accept;
  logic             handshake;
  logic [CNT_W-1:0] elem_cnt;
  logic [10:0]      dec_value;
  logic             dec_last;

  logic             s1_valid;
  logic             s1_last;
  logic [10:0]      s1_value;
  logic [2:0]       s1_exp;

  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic [2:0]       max_exp;
  logic [ACC_W:0]   sum_wide;

  assign close_pending = (state != ACCUM);
  assign out_valid     = (state == HOLD);
  assign in_ready      = ~close_pending & ~out_valid;
  assign accept        = in_valid & in_ready;
  assign handshake     = out_valid & out_ready;

  // Implicit leading one for normal codes; e==0 is a plain 0..15 value.
  always_comb begin
    dec_value = {7'd0, in_code[3:0]};
    if (in_code[6:4] != 3'd0)
      dec_value = 11'({1'b1, in_code[3:0]}) << (in_code[6:4] - 3'd1);
  end

  assign dec_last = in_last | (elem_cnt == CNT_W'(FRAME_LEN - 1));
  assign sum_wide = {1'b0, sum} + {{(ACC_W - 10){1'b0}}, s1_value};

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && dec_last) state_nxt = CLOSING;
      CLOSING: if (s1_valid && s1_last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
    end else if (handshake) begin
      elem_cnt <= '0;
    end else if (accept) begin
      elem_cnt <= dec_last ? '0 : elem_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_value <= '0;
      s1_exp   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_last  <= dec_last;
        s1_value <= dec_value;
        s1_exp   <= in_code[6:4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      count   <= '0;
      sat     <= 1'b0;
      max_exp <= '0;
    end else if (handshake) begin
      sum     <= '0;
      count   <= '0;
      sat     <= 1'b0;
      max_exp <= '0;
    end else if (s1_valid) begin
      sum     <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
      sat     <= sat | sum_wide[ACC_W];
      count   <= count + 1'b1;
      if (s1_exp > max_exp) max_exp <= s1_exp;
    end
  end

  assign out_sum     = sum;
  assign out_count   = count;
  assign out_sat     = sat;
  assign out_max_exp = max_exp;

endmodule

// File: tb/tb_minifloat_frame_accumulator.sv
// Directed bench for the minifloat frame accumulator: a 16-bit-sum instance and a
// 14-bit-sum instance share the same input stream so saturation is observable.
module tb_minifloat_frame_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_code = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_sum;
  logic [4:0]  out_count;
  logic [2:0]  out_max_exp;

  logic        s_in_ready, s_out_valid, s_out_sat;
  logic [13:0] s_out_sum;
  logic [4:0]  s_out_count;
  logic [2:0]  s_out_max_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minifloat_frame_accumulator #(.FRAME_LEN(16), .ACC_W(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat), .out_max_exp(out_max_exp)
  );

  minifloat_frame_accumulator #(.FRAME_LEN(16), .ACC_W(14), .CNT_W(5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_code(in_code), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_count(s_out_count), .out_sat(s_out_sat), .out_max_exp(s_out_max_exp)
  );

  typedef struct {
    logic [6:0] code;
    int         sum;
    int         max_exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one code and return once it has been accepted; waits counts stalled cycles.
  task automatic push(input logic [6:0] code, input logic last, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_last  = last;
    while (!in_ready && waits < 40) begin
      step();
      waits++;
    end
    chk("push_timeout", int'(waits < 40), 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_out_valid_clear", out_valid, 0);
    chk("hs_in_ready_set", in_ready, 1);
  endtask

  initial begin
    int w, stalls;

    vecs[0] = '{7'h00, 0,    0};
    vecs[1] = '{7'h0F, 15,   0};
    vecs[2] = '{7'h10, 16,   1};
    vecs[3] = '{7'h7F, 1984, 7};
    vecs[4] = '{7'h25, 42,   2};
    vecs[5] = '{7'h3A, 104,  3};
    vecs[6] = '{7'h5C, 448,  5};
    vecs[7] = '{7'h61, 544,  6};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_max_exp", out_max_exp, 0);
    rst_n = 1'b1;
    step();

    // Single-element frames exercise the decoder.
    foreach (vecs[i]) begin
      push(vecs[i].code, 1'b1, w);
      chk("dec_not_yet_valid", out_valid, 0);
      step();
      chk("dec_out_valid", out_valid, 1);
      chk($sformatf("dec_sum_%02h", vecs[i].code), out_sum, vecs[i].sum);
      chk("dec_count", out_count, 1);
      chk($sformatf("dec_max_exp_%02h", vecs[i].code), out_max_exp, vecs[i].max_exp);
      chk("dec_sat", out_sat, 0);
      take_result();
      chk("dec_sum_cleared", out_sum, 0);
    end

    // Early close on in_last.
    push(7'h15, 1'b0, w);
    push(7'h2A, 1'b0, w);
    push(7'h30, 1'b1, w);
    chk("early_in_ready_low", in_ready, 0);
    chk("early_not_yet_valid", out_valid, 0);
    step();
    chk("early_out_valid", out_valid, 1);
    chk("early_sum", out_sum, 137);
    chk("early_count", out_count, 3);
    chk("early_max_exp", out_max_exp, 3);
    chk("early_sat", out_sat, 0);
    take_result();

    // Full frame closed by the element counter, out_ready held high.
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      push(7'h7F, 1'b0, w);
      stalls += w;
    end
    chk("full_no_stalls", stalls, 0);
    chk("full_bubble1_in_ready", in_ready, 0);
    chk("full_bubble1_out_valid", out_valid, 0);
    step();
    chk("full_bubble2_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_sum", out_sum, 31744);
    chk("full_count", out_count, 16);
    chk("full_sat", out_sat, 0);
    chk("sat14_sum", s_out_sum, 16383);
    chk("sat14_sat", s_out_sat, 1);
    chk("sat14_count", s_out_count, 16);
    chk("sat14_max_exp", s_out_max_exp, 7);
    step();
    out_ready = 1'b0;
    chk("full_hs_out_valid", out_valid, 0);
    chk("full_hs_in_ready", in_ready, 1);

    push(7'h01, 1'b1, w);
    step();
    chk("sat14_next_sum", s_out_sum, 1);
    chk("sat14_next_sat", s_out_sat, 0);
    chk("sat14_next_count", s_out_count, 1);
    take_result();

    // in_last coinciding with the final counted element closes only once.
    for (int i = 0; i < 16; i++) push(7'h01, i == 15, w);
    step();
    chk("coinc_out_valid", out_valid, 1);
    chk("coinc_sum", out_sum, 16);
    chk("coinc_count", out_count, 16);
    take_result();
    push(7'h01, 1'b1, w);
    step();
    chk("coinc_next_count", out_count, 1);
    chk("coinc_next_sum", out_sum, 1);
    take_result();

    // Backpressure in HOLD with a code waiting.
    push(7'h25, 1'b1, w);
    step();
    in_valid = 1'b1;
    in_code  = 7'h7F;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", out_sum, 42);
      chk("bp_count", out_count, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_hs_out_valid", out_valid, 0);
    chk("bp_hs_in_ready", in_ready, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    chk("bp_no_accept_on_hs", out_count, 0);
    push(7'h10, 1'b1, w);
    step();
    chk("bp_after_sum", out_sum, 16);
    chk("bp_after_count", out_count, 1);
    take_result();

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 5; i++) push(7'h7F, 1'b0, w);
    chk("midrst_partial_count", out_count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", out_sum, 0);
    chk("midrst_count", out_count, 0);
    chk("midrst_max_exp", out_max_exp, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    push(7'h11, 1'b0, w);
    push(7'h11, 1'b0, w);
    push(7'h11, 1'b1, w);
    step();
    chk("postrst_out_valid", out_valid, 1);
    chk("postrst_sum", out_sum, 51);
    chk("postrst_count", out_count, 3);
    chk("postrst_max_exp", out_max_exp, 1);
    take_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
